// File: rtl/branch_resolve_unit_if.sv
// Bundle of execute-side and fetch-side signals for branch_resolve_unit.
// Handshakes (br_*, redirect_*): a transfer happens on a rising edge where valid and ready are both high; a source keeps valid and its payload steady until that edge.
interface branch_resolve_unit_if #(
  parameter int PC_WIDTH = 32
);
  logic                br_valid;
  logic                br_ready;
  logic [2:0]          br_op;
  logic [PC_WIDTH-1:0] br_pc;
  logic [31:0]         br_imm;
  logic [26:0]         br_target;
  logic [31:0]         opA;
  logic [31:0]         opB;
  logic                redirect_valid;
  logic                redirect_ready;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                flush;
  logic                busy;
  logic                link_valid;
  logic [PC_WIDTH-1:0] link_pc;
  logic [1:0]          state_dbg;

  modport slave (
    input  br_valid, br_op, br_pc, br_imm, br_target, opA, opB, redirect_ready,
    output br_ready, redirect_valid, redirect_pc, flush, busy, link_valid, link_pc, state_dbg
  );

  modport master (
    output br_valid, br_op, br_pc, br_imm, br_target, opA, opB, redirect_ready,
    input  br_ready, redirect_valid, redirect_pc, flush, busy, link_valid, link_pc, state_dbg
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves branches/jumps from execute into a registered fetch redirect followed by a bounded flush.
// Optional macro BRANCH_STATS_EN adds saturating taken/not-taken counters for conditional branches.
module branch_resolve_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int PC_WIDTH     = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  branch_resolve_unit_if.slave bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]          taken_count,
  output logic [31:0]          notaken_count
`endif
);

  localparam logic [2:0] OP_BNE = 3'b001;
  localparam logic [2:0] OP_BLT = 3'b010;
  localparam logic [2:0] OP_J   = 3'b011;
  localparam logic [2:0] OP_JAL = 3'b100;
  localparam logic [2:0] OP_JR  = 3'b101;
  localparam logic [2:0] OP_BEX = 3'b110;

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PC_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic                redirect_valid_q, redirect_valid_d;
  logic                flush_q, flush_d;
  logic                busy_q, busy_d;
  logic                link_valid_q, link_valid_d;
  logic [PC_WIDTH-1:0] link_pc_q, link_pc_d;

  logic                accept;
  logic                taken;
  logic                is_cond;
  logic [PC_WIDTH-1:0] target;

  assign accept = bus.br_valid && (state_q == IDLE);

  always_comb begin
    taken   = 1'b0;
    is_cond = 1'b0;
    target  = '0;
    unique case (bus.br_op)
      OP_BNE: begin
        is_cond = 1'b1;
        taken   = (bus.opA != bus.opB);
        target  = bus.br_pc + PC_WIDTH'(1) + PC_WIDTH'($signed(bus.br_imm));
      end
      OP_BLT: begin
        is_cond = 1'b1;
        taken   = ($signed(bus.opA) < $signed(bus.opB));
        target  = bus.br_pc + PC_WIDTH'(1) + PC_WIDTH'($signed(bus.br_imm));
      end
      OP_J, OP_JAL: begin
        taken  = 1'b1;
        target = PC_WIDTH'(bus.br_target);
      end
      OP_JR: begin
        taken  = 1'b1;
        target = PC_WIDTH'(bus.opA);
      end
      OP_BEX: begin
        is_cond = 1'b1;
        taken   = (bus.opA != 32'd0);
        target  = PC_WIDTH'(bus.br_target);
      end
      default: begin
        taken = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    redirect_pc_d = redirect_pc_q;
    link_pc_d     = link_pc_q;
    link_valid_d  = accept && (bus.br_op == OP_JAL);
    if (link_valid_d) begin
      link_pc_d = bus.br_pc + PC_WIDTH'(1);
    end
    unique case (state_q)
      IDLE: begin
        if (accept && taken) begin
          state_d       = REDIRECT;
          redirect_pc_d = target;
        end
      end
      REDIRECT: begin
        if (bus.redirect_ready) begin
          if (FLUSH_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = FLUSH;
            cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
          end
        end
      end
      FLUSH: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Outputs follow the next state so they are registered yet aligned with it.
    redirect_valid_d = (state_d == REDIRECT);
    flush_d          = (state_d != IDLE);
    busy_d           = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      redirect_pc_q    <= '0;
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
      busy_q           <= 1'b0;
      link_valid_q     <= 1'b0;
      link_pc_q        <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      redirect_pc_q    <= redirect_pc_d;
      redirect_valid_q <= redirect_valid_d;
      flush_q          <= flush_d;
      busy_q           <= busy_d;
      link_valid_q     <= link_valid_d;
      link_pc_q        <= link_pc_d;
    end
  end

  assign bus.br_ready       = (state_q == IDLE);
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush          = flush_q;
  assign bus.busy           = busy_q;
  assign bus.link_valid     = link_valid_q;
  assign bus.link_pc        = link_pc_q;
  assign bus.state_dbg      = state_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] taken_cnt_q, taken_cnt_d;
  logic [31:0] notaken_cnt_q, notaken_cnt_d;

  always_comb begin
    taken_cnt_d   = taken_cnt_q;
    notaken_cnt_d = notaken_cnt_q;
    if (accept && is_cond) begin
      if (taken && (taken_cnt_q != 32'hFFFF_FFFF)) begin
        taken_cnt_d = taken_cnt_q + 32'd1;
      end
      if (!taken && (notaken_cnt_q != 32'hFFFF_FFFF)) begin
        notaken_cnt_d = notaken_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      taken_cnt_q   <= '0;
      notaken_cnt_q <= '0;
    end else begin
      taken_cnt_q   <= taken_cnt_d;
      notaken_cnt_q <= notaken_cnt_d;
    end
  end

  assign taken_count   = taken_cnt_q;
  assign notaken_count = notaken_cnt_q;
`else
  logic unused_is_cond;
  assign unused_is_cond = is_cond;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed, table-driven bench for branch_resolve_unit (FLUSH_CYCLES=2, PC_WIDTH=32).
module tb_branch_resolve_unit;

  localparam int FC = 2;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_BNE = 3'b001;
  localparam logic [2:0] OP_BLT = 3'b010;
  localparam logic [2:0] OP_J   = 3'b011;
  localparam logic [2:0] OP_JAL = 3'b100;
  localparam logic [2:0] OP_JR  = 3'b101;
  localparam logic [2:0] OP_BEX = 3'b110;
  localparam logic [2:0] OP_111 = 3'b111;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  branch_resolve_unit_if #(.PC_WIDTH(32)) bus ();

`ifdef BRANCH_STATS_EN
  logic [31:0] taken_count, notaken_count;
`endif

  branch_resolve_unit #(.FLUSH_CYCLES(FC), .PC_WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
`ifdef BRANCH_STATS_EN
    ,
    .taken_count   (taken_count),
    .notaken_count (notaken_count)
`endif
  );

  // scoreboard
  logic [31:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [26:0] tgt;
    logic [31:0] a;
    logic [31:0] b;
    logic        taken;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.br_valid       = 1'b0;
    bus.br_op          = OP_NOP;
    bus.br_pc          = '0;
    bus.br_imm         = '0;
    bus.br_target      = '0;
    bus.opA            = '0;
    bus.opB            = '0;
    bus.redirect_ready = 1'b0;
  endtask

  task automatic drive_br(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [26:0] tgt, input logic [31:0] a, input logic [31:0] b);
    bus.br_valid  = 1'b1;
    bus.br_op     = op;
    bus.br_pc     = pc;
    bus.br_imm    = imm;
    bus.br_target = tgt;
    bus.opA       = a;
    bus.opB       = b;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".br_ready"}, 32'(bus.br_ready), 32'd1);
    check({tag, ".redirect_valid"}, 32'(bus.redirect_valid), 32'd0);
    check({tag, ".redirect_pc"}, bus.redirect_pc, 32'd0);
    check({tag, ".flush"}, 32'(bus.flush), 32'd0);
    check({tag, ".busy"}, 32'(bus.busy), 32'd0);
    check({tag, ".link_valid"}, 32'(bus.link_valid), 32'd0);
    check({tag, ".link_pc"}, bus.link_pc, 32'd0);
    check({tag, ".state"}, 32'(bus.state_dbg), 32'd0);
  endtask

  // One instruction with redirect_ready held high; ends back in IDLE.
  task automatic apply_vec(input vec_t v);
    int n;
    tick();
    drive_br(v.op, v.pc, v.imm, v.tgt, v.a, v.b);
    bus.redirect_ready = 1'b1;
    if (v.taken) exp_q.push_back(v.exp_pc);
    @(negedge clock);
    check({v.name, ".ready_c0"}, 32'(bus.br_ready), 32'd1);
    tick();
    bus.br_valid = 1'b0;
    @(negedge clock);
    check({v.name, ".redirect_valid"}, 32'(bus.redirect_valid), 32'(v.taken));
    check({v.name, ".flush"}, 32'(bus.flush), 32'(v.taken));
    check({v.name, ".busy"}, 32'(bus.busy), 32'(v.taken));
    check({v.name, ".br_ready_c1"}, 32'(bus.br_ready), 32'(!v.taken));
    if (v.taken) begin
      check({v.name, ".redirect_pc"}, bus.redirect_pc, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF);
      n = 0;
      while (!bus.br_ready && n < 20) begin
        tick();
        @(negedge clock);
        n++;
      end
      check({v.name, ".busy_cycles"}, 32'(n), 32'(FC + 1));
      check({v.name, ".flush_end"}, 32'(bus.flush), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{"bne_eq",     OP_BNE, 32'h10,       32'hFFFF_FFFC, 27'h0,       32'd5,         32'd5,         1'b0, 32'h0};
    vecs[1]  = '{"bne_ne",     OP_BNE, 32'h10,       32'hFFFF_FFFC, 27'h0,       32'd5,         32'd6,         1'b1, 32'h0000_000D};
    vecs[2]  = '{"blt_wrap",   OP_BLT, 32'hFFFF_FFFF, 32'h0,        27'h0,       32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 32'h0000_0000};
    vecs[3]  = '{"blt_signed", OP_BLT, 32'h40,       32'h8,         27'h0,       32'd5,         32'hFFFF_FFFF, 1'b0, 32'h0};
    vecs[4]  = '{"blt_neg",    OP_BLT, 32'h100,      32'h10,        27'h0,       32'hFFFF_FFFE, 32'd3,         1'b1, 32'h0000_0111};
    vecs[5]  = '{"j_max",      OP_J,   32'h50,       32'h0,         27'h7FF_FFFF, 32'd0,        32'd0,         1'b1, 32'h07FF_FFFF};
    vecs[6]  = '{"bex_zero",   OP_BEX, 32'h60,       32'h0,         27'h55,      32'd0,         32'd9,         1'b0, 32'h0};
    vecs[7]  = '{"bex_nz",     OP_BEX, 32'h60,       32'h0,         27'h55,      32'd1,         32'd0,         1'b1, 32'h0000_0055};
    vecs[8]  = '{"jr",         OP_JR,  32'h70,       32'h0,         27'h12,      32'h0000_0040, 32'd0,         1'b1, 32'h0000_0040};
    vecs[9]  = '{"nop_000",    OP_NOP, 32'h80,       32'h4,         27'h99,      32'd1,         32'd2,         1'b0, 32'h0};
    vecs[10] = '{"nop_111",    OP_111, 32'h80,       32'h4,         27'h99,      32'd1,         32'd2,         1'b0, 32'h0};
    vecs[11] = '{"bne_fwd",    OP_BNE, 32'h20,       32'h10,        27'h0,       32'd0,         32'h8000_0000, 1'b1, 32'h0000_0031};

    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clock);
    check_reset_values("reset");
`ifdef BRANCH_STATS_EN
    check("reset.taken_count", taken_count, 32'd0);
    check("reset.notaken_count", notaken_count, 32'd0);
`endif

    for (int i = 0; i < 12; i++) begin
      apply_vec(vecs[i]);
    end

    // Back-to-back not-taken branches: accepted every cycle, no bubbles.
    tick();
    bus.redirect_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) drive_br(OP_BNE, 32'($urandom_range(0, 1000)), 32'h4, 27'h0, 32'(i), 32'(i));
      else            drive_br(OP_BLT, 32'($urandom_range(0, 1000)), 32'h4, 27'h0, 32'd7, 32'd2);
      @(negedge clock);
      check("b2b.br_ready", 32'(bus.br_ready), 32'd1);
      check("b2b.busy", 32'(bus.busy), 32'd0);
      check("b2b.redirect_valid", 32'(bus.redirect_valid), 32'd0);
      tick();
    end
    bus.br_valid = 1'b0;
    @(negedge clock);
    check("b2b.after_busy", 32'(bus.busy), 32'd0);
    check("b2b.after_flush", 32'(bus.flush), 32'd0);

    // jal with fetch stalling; br_valid during the wait must not be taken.
    tick();
    drive_br(OP_JAL, 32'h20, 32'h0, 27'h123, 32'd0, 32'd0);
    bus.redirect_ready = 1'b0;
    tick();
    drive_br(OP_J, 32'h90, 32'h0, 27'h77, 32'd0, 32'd0);
    @(negedge clock);
    check("jal.link_valid_c1", 32'(bus.link_valid), 32'd1);
    check("jal.link_pc_c1", bus.link_pc, 32'h21);
    check("jal.redirect_valid_c1", 32'(bus.redirect_valid), 32'd1);
    check("jal.redirect_pc_c1", bus.redirect_pc, 32'h123);
    check("jal.br_ready_c1", 32'(bus.br_ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clock);
      check("jal.wait_valid", 32'(bus.redirect_valid), 32'd1);
      check("jal.wait_pc", bus.redirect_pc, 32'h123);
      check("jal.wait_link_valid", 32'(bus.link_valid), 32'd0);
      check("jal.wait_link_pc", bus.link_pc, 32'h21);
      check("jal.wait_br_ready", 32'(bus.br_ready), 32'd0);
    end
    tick();
    bus.br_valid       = 1'b0;
    bus.redirect_ready = 1'b1;
    @(negedge clock);
    check("jal.hs_valid", 32'(bus.redirect_valid), 32'd1);
    check("jal.hs_pc", bus.redirect_pc, 32'h123);
    tick();
    bus.redirect_ready = 1'b0;
    @(negedge clock);
    check("jal.f1_valid", 32'(bus.redirect_valid), 32'd0);
    check("jal.f1_flush", 32'(bus.flush), 32'd1);
    tick();
    @(negedge clock);
    check("jal.f2_flush", 32'(bus.flush), 32'd1);
    check("jal.f2_br_ready", 32'(bus.br_ready), 32'd0);
    tick();
    @(negedge clock);
    check("jal.idle_br_ready", 32'(bus.br_ready), 32'd1);
    check("jal.idle_flush", 32'(bus.flush), 32'd0);
    tick();
    @(negedge clock);
    check("jal.no_extra_redirect", 32'(bus.redirect_valid), 32'd0);
    check("jal.no_extra_busy", 32'(bus.busy), 32'd0);

    // jr, then reset while flushing.
    tick();
    drive_br(OP_JR, 32'h30, 32'h0, 27'h0, 32'h40, 32'd0);
    bus.redirect_ready = 1'b1;
    tick();
    bus.br_valid = 1'b0;
    @(negedge clock);
    check("jr_rst.redirect_pc", bus.redirect_pc, 32'h40);
    tick();
    @(negedge clock);
    check("jr_rst.state_flush", 32'(bus.state_dbg), 32'd2);
    check("jr_rst.flush", 32'(bus.flush), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check_reset_values("jr_rst");
`ifdef BRANCH_STATS_EN
    check("jr_rst.taken_count", taken_count, 32'd0);
    check("jr_rst.notaken_count", notaken_count, 32'd0);

    for (int i = 0; i < 3; i++) begin
      apply_vec('{"st_bex", OP_BEX, 32'h200, 32'h0, 27'h300, 32'd1 + 32'(i), 32'd0, 1'b1, 32'h300});
    end
    for (int i = 0; i < 2; i++) begin
      apply_vec('{"st_blt", OP_BLT, 32'h210, 32'h4, 27'h0, 32'd9, 32'd1, 1'b0, 32'h0});
    end
    apply_vec('{"st_j", OP_J, 32'h220, 32'h0, 27'h44, 32'd0, 32'd0, 1'b1, 32'h44});
    check("stats.taken_count", taken_count, 32'd3);
    check("stats.notaken_count", notaken_count, 32'd2);
`endif

    check("sb.queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
